// File: rtl/cnt_share_pkg.sv
// rtl/cnt_share_pkg.sv - shared counter controller state encoding and helpers
package cnt_share_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        SETTLE   = 3'd1,
        ARB      = 3'd2,
        SAMPLE   = 3'd3,
        OVF_WAIT = 3'd4,
        LOCK     = 3'd5
    } state_t;

    function automatic logic [31:0] onehot32(input int unsigned idx);
        onehot32 = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/cnt_share_ctrl_rr_arbiter.sv
// rtl/cnt_share_ctrl_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] winner,
    output logic          any
);

    // Scan ptr, ptr+1, ... wrapping at N; the first set bit wins.
    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any    = 1'b1;
                winner = PW'((int'(ptr) + i) % N);
            end
        end
        if (any) gnt[winner] = 1'b1;
    end

endmodule

// File: rtl/cnt_share_ctrl.sv
// rtl/cnt_share_ctrl.sv - shares one overflow event counter between NREQ requesters
module cnt_share_ctrl
    import cnt_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic [NREQ-1:0]  ovf_flag,
    input  logic [NREQ-1:0]  ovf_ack,
    input  logic             restart,
    output logic             cnt_ena,
    output logic             cnt_reinit,
    output logic             cnt_clr_ovf,
    input  logic [WIDTH-1:0] cnt_value,
    input  logic             cnt_overflow,
    input  logic             cnt_ovf_err,
    output logic [WIDTH-1:0] snap_value,
    output logic             busy,
    output logic             locked
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, owner, winner;
    logic [NREQ-1:0] gnt;
    logic            any;
    logic            grant;
    logic [31:0]     owner_oh;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .gnt    (gnt),
        .winner (winner),
        .any    (any)
    );

    assign owner_oh = onehot32(32'(owner));

    always_comb begin
        state_nx    = state;
        grant       = 1'b0;
        cnt_reinit  = 1'b0;
        cnt_clr_ovf = 1'b0;
        case (state)
            INIT: begin
                cnt_reinit = 1'b1;
                state_nx   = SETTLE;
            end
            SETTLE: state_nx = ARB;
            ARB: begin
                if (cnt_ovf_err)       state_nx = LOCK;
                else if (cnt_overflow) state_nx = OVF_WAIT;
                else if (any) begin
                    grant    = 1'b1;
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                if (cnt_ovf_err)       state_nx = LOCK;
                else if (cnt_overflow) state_nx = OVF_WAIT;
                else                   state_nx = ARB;
            end
            OVF_WAIT: begin
                if (ovf_ack[owner]) begin
                    cnt_clr_ovf = 1'b1;
                    state_nx    = ARB;
                end
            end
            LOCK:    state_nx = LOCK;
            default: state_nx = INIT;
        endcase
        // restart beats any grant or overflow clear issued in the same cycle
        if (restart) begin
            state_nx    = INIT;
            grant       = 1'b0;
            cnt_clr_ovf = 1'b0;
        end
        if (reset) begin
            grant       = 1'b0;
            cnt_reinit  = 1'b0;
            cnt_clr_ovf = 1'b0;
        end
    end

    assign cnt_ena = grant;
    assign ack     = grant ? gnt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            ptr        <= '0;
            owner      <= '0;
            ovf_flag   <= '0;
            snap_value <= '0;
            busy       <= 1'b1;
            locked     <= 1'b0;
        end else begin
            state  <= state_nx;
            busy   <= (state_nx != ARB);
            locked <= (state_nx == LOCK);
            if (restart) begin
                ovf_flag <= '0;
                ptr      <= '0;
            end else begin
                if (grant) begin
                    owner <= winner;
                    ptr   <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
                end
                if (state == SAMPLE) begin
                    snap_value <= cnt_value;
                    if (!cnt_ovf_err && cnt_overflow) ovf_flag <= owner_oh[NREQ-1:0];
                end
                if (cnt_clr_ovf) ovf_flag <= '0;
            end
        end
    end

endmodule
